// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares the CPU memory bus with a 256-byte OAM sprite DMA.
// Define OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN state and its parity tracker.
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        tick_i,
  input  logic [15:0] cpu_address_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_bus_read_i,
  input  logic        cpu_bus_write_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic [15:0] mem_address_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_data_valid_i,
  output logic        dma_active_o,
  output logic        dma_done_o
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [7:0] page_q, page_d, count_q, count_d, hold_q, hold_d;
  logic idle, trigger, align_go;
  assign idle    = state_q == IDLE;
  assign trigger = cpu_bus_write_i && cpu_address_i == TRIGGER_ADDR;
`ifdef OAM_DMA_ALIGN_EN
  logic parity_q, parity_d;
  assign parity_d = parity_q ^ tick_i;
  assign align_go = parity_q;
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) parity_q <= 1'b0;
    else parity_q <= parity_d;
`else
  assign align_go = 1'b0;
`endif
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      page_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      page_q  <= page_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    count_d = count_q;
    hold_d  = hold_q;
    if (tick_i)
      case (state_q)
        IDLE: if (trigger) begin
          page_d  = cpu_data_i;
          count_d = '0;
          state_d = HALT;
        end
        HALT:  state_d = align_go ? ALIGN : READ;
        ALIGN: state_d = READ;
        READ: if (mem_data_valid_i) begin
          hold_d  = mem_data_i;
          state_d = WRITE;
        end
        WRITE: if (count_q == 8'hFF) state_d = IDLE;
        else begin
          count_d = count_q + 8'd1;
          state_d = READ;
        end
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    mem_address_o    = idle ? cpu_address_i : state_q == WRITE ? OAM_DATA_ADDR : {page_q, count_q};
    mem_data_o       = idle ? cpu_data_i : hold_q;
    mem_read_o       = idle ? cpu_bus_read_i : state_q == READ;
    mem_write_o      = idle ? cpu_bus_write_i : state_q == WRITE;
    cpu_data_o       = idle ? mem_data_i : hold_q;
    cpu_data_valid_o = idle && mem_data_valid_i;
    dma_active_o     = !idle;
    dma_done_o       = state_q == WRITE && tick_i && count_q == 8'hFF;
  end
endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sits between `cpu` and the system memory bus; owns the bus shared by the CPU and an OAM sprite-DMA engine.
- A CPU write to the DMA trigger register starts a DMA transfer. The block then stalls the CPU by withholding data-valid and copies 256 bytes from page {data,00}..{data,FF} to the PPU OAM data port.
- Paced by the same CPU tick strobe the CPU uses internally.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clock_i  in  1  system clock.
- reset_ni  in  1  asynchronous, active-low reset.
- tick_i  in  1  one-cycle CPU-cycle strobe; all state advances only when tick_i=1.
- cpu_address_i  in  16  CPU bus address.
- cpu_data_i  in  8  CPU write data.
- cpu_bus_read_i  in  1  CPU read request.
- cpu_bus_write_i  in  1  CPU write request.
- cpu_data_o  out  8  read data to CPU.
- cpu_data_valid_o  out  1  data-valid to CPU; 0 = CPU stalled.
- mem_address_o  out  16  memory bus address.
- mem_data_o  out  8  memory write data.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_data_i  in  8  memory read data.
- mem_data_valid_i  in  1  memory read data valid.
- dma_active_o  out  1  high while the DMA owns the bus.
- dma_done_o  out  1  one-clock pulse when the final byte is written.

Behaviour:
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers: state, page[7:0], count[7:0], hold[7:0], parity.
- Reset (asynchronous, reset_ni=0):
  - state=IDLE, page=0, count=0, hold=0, parity=0.
  - dma_active_o=0, dma_done_o=0.
  - Bus outputs follow the IDLE pass-through.
- parity toggles on every tick_i from reset; it never stops.
- IDLE (pass-through, combinational):
  - mem_address_o=cpu_address_i, mem_data_o=cpu_data_i.
  - mem_read_o=cpu_bus_read_i, mem_write_o=cpu_bus_write_i.
  - cpu_data_o=mem_data_i, cpu_data_valid_o=mem_data_valid_i.
  - On tick_i with cpu_bus_write_i=1 and cpu_address_i==TRIGGER_ADDR:
    - The trigger write is still forwarded to memory this tick.
    - page<=cpu_data_i, count<=0, state<=HALT.
- Non-IDLE states:
  - cpu_data_valid_o=0 and dma_active_o=1.
  - cpu_data_o=hold.
  - CPU request inputs are ignored, including any repeated trigger writes.
- HALT: no bus access (mem_read_o=0, mem_write_o=0). On tick_i:
  - state<=ALIGN if parity==1, else READ.
- ALIGN: no bus access. On tick_i: state<=READ.
- READ:
  - mem_address_o={page,count}, mem_read_o=1, mem_write_o=0.
  - On tick_i with mem_data_valid_i=1: hold<=mem_data_i, state<=WRITE.
  - On tick_i with mem_data_valid_i=0: stay in READ (retry).
- WRITE:
  - mem_address_o=OAM_DATA_ADDR, mem_data_o=hold, mem_write_o=1, mem_read_o=0.
  - On tick_i with count==8'hFF: state<=IDLE and dma_done_o pulses.
  - On tick_i otherwise: count<=count+1, state<=READ.
- count is 8-bit. The last source address is {page,8'hFF}; the source never crosses a page.
- Latency with zero wait states: stall = 1 (HALT) + 0 or 1 (ALIGN) + 512 = 513 or 514 ticks.
- The CPU sees cpu_data_valid_o return on the tick after the final WRITE.
- tick_i=0: all state holds; combinational outputs remain stable.
- Reset asserted mid-DMA: immediate return to IDLE. The transfer is abandoned and not resumed; OAM is left partially written.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: the ALIGN state exists, and odd-parity triggers cost 514 ticks.
- Undefined: HALT always goes to READ, the stall is always 513 ticks, and the parity register is not synthesised.

Test Plan:
- Reset behaviour: hold reset_ni=0, then release. IDLE pass-through holds: a CPU read of 16'h8000 with memory returning 8'h5A gives cpu_data_o=8'h5A, cpu_data_valid_o=1, dma_active_o=0.
- Basic transfer: CPU writes 8'h02 to 16'h4014 with page 16'h0200..02FF = index value.
  - 256 writes to 16'h2004 occur with data 00..FF in order.
  - cpu_data_valid_o=0 for exactly 513 ticks (even parity); dma_done_o pulses once.
- Alignment (OAM_DMA_ALIGN_EN defined): trigger on an odd-parity tick. The stall is 514 ticks, with one extra tick where mem_read_o=mem_write_o=0 before the first read.
- Memory wait states: hold mem_data_valid_i=0 for 3 ticks on read #5.
  - READ retries at {page,8'h05}; no write is issued early.
  - Total stall grows by 3; data order is intact.
- Reset mid-DMA: pull reset_ni low after 100 writes.
  - dma_active_o=0 immediately (asynchronous); no further mem_write_o.
  - After release, the next trigger starts again from count=0.
- Non-trigger writes: a CPU write to 16'h4015 or 16'h2004 passes through and does not start DMA. A write to 16'h4014 with tick_i=0 does not start DMA.
